sonic_rx_dma_burst_requester: RTL

Read-side consumer of the dual-clock FIFO occupancy calculator: it watches `rdusedqwords`/`empty` in the read clock domain, turns accumulated qwords into host DMA burst requests, and then drains exactly the granted number of qwords from the FIFO with `rdreq`. It sits between the FIFO read port and the PCIe DMA write engine. It generates ring-buffer addresses with wrap-around and flushes partial bursts on demand or on an idle timeout.

---
 rtl/sonic_dma_burst_pkg.sv | 31 +++
 rtl/sonic_common_idle_timer.sv | 37 +++
 rtl/sonic_rx_dma_burst_requester.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/sonic_dma_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sonic_dma_burst_pkg
// Purpose  : Shared types, constants and the length-clamp helper for the
//            RX DMA burst requester.
// Revision : 1.0 - initial release
// ============================================================================
package sonic_dma_burst_pkg;

    // FIFO occupancy width; 13 bits holds a full 4096-qword ring.
    localparam int USED_QWORDS_WIDTH = 13;
    localparam int QWORD_BYTES       = 8;
    localparam int CALC_W            = USED_QWORDS_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        GAP  = 2'd3
    } burst_state_t;

    typedef logic [CALC_W-1:0] calc_t;

    function automatic calc_t min3(input calc_t a, input calc_t b, input calc_t c);
        calc_t m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sonic_common_idle_timer.sv
`default_nettype none
// ============================================================================
// Module   : sonic_common_idle_timer
// Purpose  : Saturating cycle counter with synchronous clear and a one-cycle
//            terminal pulse on the step that reaches COUNT_MAX.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_common_idle_timer #(
    parameter int COUNT_MAX = 256
) (
    input  logic clock,
    input  logic reset,
    input  logic i_count_en,
    input  logic i_clear,
    output logic o_terminal
);

    localparam int c_cnt_w = $clog2(COUNT_MAX + 1);

    logic [c_cnt_w-1:0] r_count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_count_en) begin
            if (i_clear) begin
                r_count <= '0;
            end else if (r_count != c_cnt_w'(COUNT_MAX)) begin
                r_count <= r_count + c_cnt_w'(1);
            end
        end
    end

    assign o_terminal = i_count_en && !i_clear && (r_count == c_cnt_w'(COUNT_MAX - 1));

endmodule
`default_nettype wire

// File: rtl/sonic_rx_dma_burst_requester.sv
`default_nettype none
// ============================================================================
// Module   : sonic_rx_dma_burst_requester
// Purpose  : Turns FIFO occupancy into host DMA burst requests on a wrapping
//            ring, then drains exactly the granted qwords with rdreq.
//            Optional idle-timeout flush: define SONIC_BURST_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sonic_rx_dma_burst_requester
    import sonic_dma_burst_pkg::*;
#(
    parameter int                ADDR_W         = 32,
    parameter int                BURST_QWORDS   = 16,
    parameter int                RING_QWORDS    = 4096,
    parameter logic [ADDR_W-1:0] RING_BASE      = '0,
    parameter int                TIMEOUT_CYCLES = 256,
    parameter int                GAP_CYCLES     = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ena,
    input  logic [USED_QWORDS_WIDTH-1:0]  rdusedqwords,
    input  logic                          empty,
    input  logic                          flush,
    output logic                          rdreq,
    output logic                          req_valid,
    input  logic                          req_ready,
    output logic [ADDR_W-1:0]             req_addr,
    output logic [$clog2(BURST_QWORDS):0] req_len,
    input  logic                          xfer_ready,
    output logic                          busy,
    output logic [31:0]                   burst_count
);

    localparam int    c_len_w = $clog2(BURST_QWORDS) + 1;
    localparam int    c_off_w = $clog2(RING_QWORDS);
    localparam int    c_gap_w = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam calc_t c_burst = calc_t'(BURST_QWORDS);
    localparam calc_t c_ring  = calc_t'(RING_QWORDS);

    burst_state_t        r_state;
    burst_state_t        w_state_next;
    logic [c_off_w-1:0]  r_wr_offset;
    logic [c_len_w-1:0]  r_req_len;
    logic [c_len_w-1:0]  r_remaining;
    logic [ADDR_W-1:0]   r_req_addr;
    logic                r_req_valid;
    logic                r_busy;
    logic                r_flush_pending;
    logic [31:0]         r_burst_count;
    logic [c_gap_w-1:0]  r_gap_cnt;

    calc_t               w_avail;
    calc_t               w_room;
    logic [c_len_w-1:0]  w_len;
    logic [c_off_w-1:0]  w_next_offset;
    logic [ADDR_W-1:0]   w_entry_addr;
    logic                w_go;
    logic                w_idle_go;
    logic                w_accept;
    logic                w_rdreq;
    logic                w_last_qword;
    logic                w_flush_clr;
    logic                w_timeout;

    assign w_avail       = empty ? '0 : {1'b0, rdusedqwords};
    assign w_room        = c_ring - calc_t'(r_wr_offset);
    assign w_len         = c_len_w'(min3(w_avail, c_burst, w_room));
    assign w_go          = (w_avail >= c_burst)
                         || ((w_room < c_burst) && (w_avail >= w_room))
                         || (r_flush_pending && (w_avail != '0));
    assign w_idle_go     = ena && (r_state == IDLE) && w_go;
    assign w_accept      = ena && (r_state == REQ) && req_ready;
    assign w_rdreq       = ena && (r_state == XFER) && xfer_ready;
    assign w_last_qword  = w_rdreq && (r_remaining == c_len_w'(1));
    // Power-of-two ring: truncating the sum is the modulo.
    assign w_next_offset = r_wr_offset + c_off_w'(r_req_len);
    assign w_entry_addr  = RING_BASE + ADDR_W'(r_wr_offset) * ADDR_W'(QWORD_BYTES);
    assign w_flush_clr   = w_accept || (ena && (r_state == IDLE) && (w_avail == '0));

`ifdef SONIC_BURST_TIMEOUT_EN
    logic w_partial;
    assign w_partial = (w_avail != '0) && (w_avail < c_burst);

    sonic_common_idle_timer #(
        .COUNT_MAX (TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clock      (clock),
        .reset      (reset),
        .i_count_en (ena),
        .i_clear    (!((r_state == IDLE) && w_partial && !w_go)),
        .o_terminal (w_timeout)
    );
`else
    // No timer in this build; the parameter stays for a uniform interface.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (ena) begin
            case (r_state)
                IDLE:    if (w_go) w_state_next = REQ;
                REQ:     if (req_ready) w_state_next = XFER;
                XFER:    if (w_last_qword) w_state_next = GAP;
                GAP:     if (r_gap_cnt == '0) w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_offset     <= '0;
            r_req_len       <= '0;
            r_remaining     <= '0;
            r_req_addr      <= RING_BASE;
            r_req_valid     <= 1'b0;
            r_busy          <= 1'b0;
            r_flush_pending <= 1'b0;
            r_burst_count   <= '0;
            r_gap_cnt       <= '0;
        end else begin
            // A new flush wins over a same-cycle clear so it is never lost.
            r_flush_pending <= flush || w_timeout || (r_flush_pending && !w_flush_clr);
            if (ena) begin
                r_req_valid <= (w_state_next == REQ);
                r_busy      <= (w_state_next != IDLE);
                if (w_idle_go) begin
                    r_req_len  <= w_len;
                    r_req_addr <= w_entry_addr;
                end
                if (w_accept) begin
                    r_wr_offset   <= w_next_offset;
                    r_burst_count <= r_burst_count + 32'd1;
                    r_remaining   <= r_req_len;
                end else if (w_rdreq) begin
                    r_remaining <= r_remaining - c_len_w'(1);
                end
                if (w_last_qword) begin
                    r_gap_cnt <= c_gap_w'(GAP_CYCLES - 1);
                end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                    r_gap_cnt <= r_gap_cnt - c_gap_w'(1);
                end
            end
        end
    end

    assign rdreq       = w_rdreq;
    assign req_valid   = r_req_valid;
    assign req_addr    = r_req_addr;
    assign req_len     = r_req_len;
    assign busy        = r_busy;
    assign burst_count = r_burst_count;

endmodule
`default_nettype wire
